// File: rtl/adc_acq_sequencer.sv
// ADC acquisition sequencer: drops settling samples, then averages 2^N samples and reports mean/min/max.
// Build option: define ADC_ACQ_ROUND_EN for a round-half-up mean instead of truncation.
module adc_acq_sequencer #(
    parameter int DATA_W         = 16,
    parameter int MAX_AVG_LOG2   = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        avg_log2,
    input  logic [3:0]        discard_count,
    input  logic              adc_new_data,
    input  logic [DATA_W-1:0] adc_data,
    output logic              busy,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [DATA_W-1:0] result_mean,
    output logic [DATA_W-1:0] result_min,
    output logic [DATA_W-1:0] result_max,
    output logic              timeout_err
);
    localparam int ACC_W = DATA_W + MAX_AVG_LOG2;
    localparam int CNT_W = MAX_AVG_LOG2 + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]       N_MAX    = 4'(MAX_AVG_LOG2);
    // tmo_q lags the cycles-since-event count by one, so firing here raises
    // result_valid exactly TIMEOUT_CYCLES cycles after the last event.
    localparam logic [TMO_W-1:0] TMO_FIRE = TMO_W'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_DISCARD, S_ACCUM, S_CALC, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [2:0]        sync_q;
    logic              evt;
    logic [3:0]        n_q;
    logic [3:0]        disc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_last;
    logic [ACC_W-1:0]  acc_q;
    logic [DATA_W-1:0] min_q, max_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [DATA_W-1:0] mean_q, rmin_q, rmax_q;
    logic              tmo_err_q;
    logic [DATA_W-1:0] mean_calc;
    logic              acquiring, start_ok, last_smp, tmo_hit;
    logic [3:0]        n_clamped;

    // Two flops of synchronizer plus one for the rising-edge detector.
    always_ff @(posedge clk_50MHz) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[1:0], adc_new_data};
    end
    assign evt = sync_q[1] & ~sync_q[2];

    assign acquiring = (state_q == S_DISCARD) || (state_q == S_ACCUM);
    assign start_ok  = (state_q == S_IDLE) && start;
    assign cnt_last  = CNT_W'((32'd1 << n_q) - 32'd1);
    assign last_smp  = (state_q == S_ACCUM) && evt && (cnt_q == cnt_last);
    assign tmo_hit   = acquiring && !evt && (tmo_q == TMO_FIRE);
    assign n_clamped = (avg_log2 > N_MAX) ? N_MAX : avg_log2;

`ifdef ADC_ACQ_ROUND_EN
    localparam logic [ACC_W:0] RND_ONE = 1;
    logic [ACC_W:0] acc_rnd;
    always_comb begin
        acc_rnd = {1'b0, acc_q};
        if (n_q != 4'd0) acc_rnd = acc_rnd + (RND_ONE << (n_q - 4'd1));
    end
    assign mean_calc = DATA_W'(acc_rnd >> n_q);
`else
    assign mean_calc = DATA_W'(acc_q >> n_q);
`endif

    always_ff @(posedge clk_50MHz) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = (discard_count != 4'd0) ? S_DISCARD : S_ACCUM;
            S_DISCARD: if (tmo_hit) state_d = S_DONE;
                       else if (evt && disc_q == 4'd1) state_d = S_ACCUM;
            S_ACCUM:   if (tmo_hit) state_d = S_DONE;
                       else if (last_smp) state_d = S_CALC;
            S_CALC:    state_d = S_DONE;
            S_DONE:    if (result_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        result_valid = (state_q == S_DONE);
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            n_q       <= '0;
            disc_q    <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            tmo_q     <= '0;
            mean_q    <= '0;
            rmin_q    <= '0;
            rmax_q    <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if (start_ok) begin
                n_q    <= n_clamped;
                disc_q <= discard_count;
                cnt_q  <= '0;
                acc_q  <= '0;
                min_q  <= '1;
                max_q  <= '0;
                tmo_q  <= '0;
            end
            if (acquiring) begin
                tmo_q <= evt ? '0 : tmo_q + TMO_W'(1);
                if (evt && state_q == S_DISCARD) disc_q <= disc_q - 4'd1;
                if (evt && state_q == S_ACCUM) begin
                    acc_q <= acc_q + ACC_W'(adc_data);
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (adc_data < min_q) min_q <= adc_data;
                    if (adc_data > max_q) max_q <= adc_data;
                end
            end
            if (state_q == S_CALC) begin
                mean_q    <= mean_calc;
                rmin_q    <= min_q;
                rmax_q    <= max_q;
                tmo_err_q <= 1'b0;
            end
            if (tmo_hit) begin
                mean_q    <= '0;
                rmin_q    <= min_q;
                rmax_q    <= max_q;
                tmo_err_q <= 1'b1;
            end
            if (state_q == S_DONE && result_ready) tmo_err_q <= 1'b0;
        end
    end

    assign result_mean = mean_q;
    assign result_min  = rmin_q;
    assign result_max  = rmax_q;
    assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Directed bench for adc_acq_sequencer with hand-computed expectations.
module tb_adc_acq_sequencer;
    localparam int DATA_W = 16;

`ifdef ADC_ACQ_ROUND_EN
    localparam logic [15:0] EXP_BASIC = 16'd102;
`else
    localparam logic [15:0] EXP_BASIC = 16'd101;
`endif

    logic              clk_50MHz = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [3:0]        avg_log2 = '0;
    logic [3:0]        discard_count = '0;
    logic              adc_new_data = 1'b0;
    logic [DATA_W-1:0] adc_data = '0;
    logic              busy, result_valid;
    logic              result_ready = 1'b0;
    logic [DATA_W-1:0] result_mean, result_min, result_max;
    logic              timeout_err;

    int vectors = 0;
    int errors  = 0;
    logic seen_valid;

    adc_acq_sequencer #(.DATA_W(16), .MAX_AVG_LOG2(8), .TIMEOUT_CYCLES(100)) dut (
        .clk_50MHz(clk_50MHz), .reset(reset), .start(start), .avg_log2(avg_log2),
        .discard_count(discard_count), .adc_new_data(adc_new_data), .adc_data(adc_data),
        .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
        .result_mean(result_mean), .result_min(result_min), .result_max(result_max),
        .timeout_err(timeout_err)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_50MHz);
        #1;
    endtask

    // Returns inside the cycle in which the DUT detects the sample event.
    task automatic drive_sample(input logic [15:0] v);
        adc_data     = v;
        adc_new_data = 1'b1;
        idle(2);
        adc_new_data = 1'b0;
    endtask

    task automatic sample(input logic [15:0] v);
        drive_sample(v);
        idle(2);
    endtask

    task automatic do_start(input logic [3:0] n, input logic [3:0] d);
        avg_log2      = n;
        discard_count = d;
        start         = 1'b1;
        idle(1);
        start         = 1'b0;
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        idle(1);
        result_ready = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [15:0] mn, input logic [15:0] lo,
                              input logic [15:0] hi, input logic te);
        chk1 ({tag, ".valid"}, result_valid, 1'b1);
        chk16({tag, ".mean"},  result_mean, mn);
        chk16({tag, ".min"},   result_min,  lo);
        chk16({tag, ".max"},   result_max,  hi);
        chk1 ({tag, ".terr"},  timeout_err, te);
    endtask

    initial begin
        idle(3);
        reset = 1'b0;
        chk1 ("rst.busy",  busy, 1'b0);
        chk1 ("rst.valid", result_valid, 1'b0);
        chk16("rst.mean",  result_mean, 16'd0);
        chk16("rst.min",   result_min,  16'd0);
        chk16("rst.max",   result_max,  16'd0);
        chk1 ("rst.terr",  timeout_err, 1'b0);

        // Basic average, N=2, no discard
        do_start(4'd2, 4'd0);
        chk1("basic.busy", busy, 1'b1);
        sample(16'd100);
        sample(16'd101);
        sample(16'd102);
        drive_sample(16'd104);
        chk1("basic.valid_evt", result_valid, 1'b0);
        idle(1);
        chk1("basic.valid_p1", result_valid, 1'b0);
        chk1("basic.busy_p1",  busy, 1'b1);
        idle(1);
        chk_result("basic", EXP_BASIC, 16'd100, 16'd104, 1'b0);
        handshake();
        chk1 ("basic.hs_valid", result_valid, 1'b0);
        chk1 ("basic.hs_busy",  busy, 1'b0);
        chk16("basic.hs_mean",  result_mean, EXP_BASIC);

        // Reset mid-accumulation aborts without a result
        do_start(4'd2, 4'd0);
        sample(16'd10);
        sample(16'd20);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk1 ("midrst.busy",  busy, 1'b0);
        chk1 ("midrst.valid", result_valid, 1'b0);
        chk16("midrst.mean",  result_mean, 16'd0);
        chk16("midrst.min",   result_min,  16'd0);
        chk16("midrst.max",   result_max,  16'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample(16'd30);
            if (result_valid || busy) seen_valid = 1'b1;
        end
        idle(10);
        if (result_valid || busy) seen_valid = 1'b1;
        chk1("midrst.no_valid", seen_valid, 1'b0);

        // Discard 3 settling samples, N=0
        do_start(4'd0, 4'd3);
        sample(16'd9);
        sample(16'd9);
        sample(16'd9);
        drive_sample(16'd500);
        idle(1);
        chk1("disc.valid_p1", result_valid, 1'b0);
        idle(1);
        chk_result("disc", 16'd500, 16'd500, 16'd500, 1'b0);

        // Hold result with ready low while start pulses arrive
        for (int i = 0; i < 5; i++) begin
            do_start(4'd1, 4'd0);
            idle(9);
            chk1 ("hold.valid", result_valid, 1'b1);
            chk16("hold.mean",  result_mean, 16'd500);
        end
        chk_result("hold", 16'd500, 16'd500, 16'd500, 1'b0);
        avg_log2      = 4'd0;
        discard_count = 4'd0;
        result_ready  = 1'b1;
        start         = 1'b1;
        idle(1);
        result_ready  = 1'b0;
        start         = 1'b0;
        chk1("coll.valid", result_valid, 1'b0);
        chk1("coll.busy",  busy, 1'b0);
        idle(3);
        chk1("coll.noqueue", busy, 1'b0);
        do_start(4'd0, 4'd0);
        chk1("coll.restart", busy, 1'b1);
        sample(16'd42);
        chk_result("coll", 16'd42, 16'd42, 16'd42, 1'b0);
        handshake();

        // avg_log2=15 clamps to 8: exactly 256 samples
        do_start(4'd15, 4'd0);
        for (int i = 0; i < 256; i++) begin
            sample(16'hFFFF);
            if (i == 254) chk1("clamp.valid_255", result_valid, 1'b0);
        end
        chk_result("clamp", 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
        sample(16'h0000);
        chk_result("clamp257", 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
        handshake();

        // Timeout after two samples, N=3
        do_start(4'd3, 4'd0);
        sample(16'd5);
        drive_sample(16'd7);
        idle(99);
        chk1("tmo.valid_99", result_valid, 1'b0);
        idle(1);
        chk_result("tmo", 16'd0, 16'd5, 16'd7, 1'b1);
        handshake();
        chk1 ("tmo.hs_valid", result_valid, 1'b0);
        chk1 ("tmo.hs_terr",  timeout_err, 1'b0);
        chk16("tmo.hs_min",   result_min, 16'd5);

        // Timeout while still discarding: no samples taken
        do_start(4'd1, 4'd5);
        idle(105);
        chk_result("tmodisc", 16'd0, 16'hFFFF, 16'd0, 1'b1);
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/adc_acq_sequencer.md
Name: adc_acq_sequencer

Overview:
Sequences sample acquisition from the serial ADC front-end. It runs on the 50 MHz system clock and consumes the front-end's new-data flag and 16-bit sample word. On a start request it discards a programmable number of settling samples, then accumulates 2^N samples. It returns mean, min and max through a valid/ready result handshake, with a no-data timeout to guard against a stalled ADC.

Parameters:
DATA_W, 16, sample width, unsigned.
MAX_AVG_LOG2, 8, maximum averaging exponent; accumulator width = DATA_W + MAX_AVG_LOG2.
TIMEOUT_CYCLES, 65535, clk_50MHz cycles allowed between accepted samples before abort.

Ports:
clk_50MHz  input  1  system clock.
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle acquisition request.
avg_log2  input  4  averaging exponent N; values > MAX_AVG_LOG2 clamp to MAX_AVG_LOG2; latched on accepted start.
discard_count  input  4  settling samples to drop before accumulation; latched on accepted start.
adc_new_data  input  1  new-data flag from ADC front-end; SCLK-domain, treated as asynchronous.
adc_data  input  DATA_W  sample word from ADC front-end; stable for at least 2 SCLK periods after flag rises.
busy  output  1  high in DISCARD, ACCUM and DONE.
result_valid  output  1  result available.
result_ready  input  1  consumer accepts result.
result_mean  output  DATA_W  accumulator >> N.
result_min  output  DATA_W  minimum accumulated sample.
result_max  output  DATA_W  maximum accumulated sample.
timeout_err  output  1  result terminated by timeout; qualified by result_valid.

Behaviour:
- Flag handling: adc_new_data passes through a 2-FF synchronizer and then a rising-edge detector, giving 1 "sample event" per flag rise. The flag must be high and low for at least 2 clk_50MHz cycles each.
- adc_data is registered in the cycle the sample event is detected. The synchronizer delay guarantees the word is stable by then.
- Reset: state = IDLE; busy, result_valid and timeout_err = 0; result_mean, result_min and result_max = 0; accumulator and counters = 0.
- A reset asserted mid-acquisition aborts immediately. No result is produced.
- IDLE:
  - start=1 latches avg_log2 (clamped) and discard_count, clears the accumulator, sets running min = all-ones and running max = 0, clears the timeout counter.
  - Next state is DISCARD if discard_count != 0, else ACCUM.
  - A sample event in the same cycle as start is not counted.
- DISCARD: each sample event decrements the discard counter. When it reaches 0, go to ACCUM. Sample values are ignored.
- ACCUM:
  - Each sample event adds the sample to the accumulator, updates min/max and increments the sample counter.
  - After the 2^N-th sample, go to DONE.
  - result_valid rises 2 cycles after the final sample event is detected. The cycle in between computes mean and registers outputs.
  - N=0 means a single sample; mean = sample.
- Mean: unsigned accumulator shifted right by N, with truncation. The accumulator cannot overflow: its width is DATA_W + MAX_AVG_LOG2.
- Timeout:
  - In DISCARD or ACCUM, the counter increments each cycle without a sample event and clears on each event.
  - On reaching TIMEOUT_CYCLES, go to DONE with timeout_err=1, result_mean=0, and min/max as accumulated so far. If no sample was taken, min = all-ones and max = 0.
- DONE:
  - result_valid=1. All result outputs are held stable until result_valid & result_ready.
  - On the handshake cycle, go to IDLE; result_valid drops the next cycle. The result data registers keep their values; timeout_err clears.
  - result_ready may be high before valid. The handshake completes in the first valid cycle.
- start while busy, including in DONE and on the handshake cycle, is ignored and not queued.
- Sample events in IDLE and DONE are ignored.

Optional Feature:
ADC_ACQ_ROUND_EN
- Defined: the mean is computed as (accumulator + 2^(N-1)) >> N, i.e. round-half-up. No rounding is applied for N=0. No saturation is needed because the accumulator is widened by 1 bit for the addition.
- Undefined: the mean is truncated as specified above, with no extra logic.

Test Plan:
- Reset mid-ACCUM: start N=2, 2 samples in, assert reset 1 cycle -> busy=0, result_valid=0, all results 0; no valid ever appears.
- Basic average: N=2, discard=0, samples 100, 101, 102, 104 -> mean=101 (102 with ADC_ACQ_ROUND_EN), min=100, max=104, timeout_err=0; valid rises exactly 2 cycles after 4th event.
- Discard and N=0: discard=3, N=0, samples 9, 9, 9, 500 -> mean=min=max=500.
- Clamp and range: avg_log2=15 with MAX_AVG_LOG2=8, feed 256 samples of 0xFFFF -> mean=0xFFFF; the 257th sample is not counted.
- Timeout: TIMEOUT_CYCLES=100, N=3, 2 samples (5, 7) then silence -> valid with timeout_err=1, mean=0, min=5, max=7, exactly 100 cycles after the last event.
- Handshake/start collisions: hold result_ready=0 for 50 cycles with start pulses -> outputs stable, no restart; ready=1 with start same cycle -> IDLE, next start accepted only on a later pulse.
